burst_line_adaptor: RTL and testbench

- Parametrised successor to the fixed 256-bit/4-beat line adaptor.
- Sits between the last-level cache and the burst memory port.
- Serialises a cache line into BURSTS beats of BURST_WIDTH bits on write, and reassembles beats into a full line on read.
- New over the previous generation:
  - Generic line, beat and address widths.
  - Request capture: upstream may change inputs after acceptance.
  - Line-aligned base address.
  - Optional per-beat address increment.
  - Read/write conflict rejection with a sticky error flag.

---
 rtl/burst_adaptor_pkg.sv | 10 +
 rtl/burst_line_adaptor_if.sv | 30 +++
 rtl/burst_shift_buf.sv | 28 ++
 rtl/burst_line_adaptor.sv | 81 ++++++++
 tb/tb_burst_line_adaptor.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/burst_adaptor_pkg.sv
// burst_adaptor_pkg: shared FSM state type and line-alignment helper for the burst line adaptor
package burst_adaptor_pkg;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   function automatic logic [63:0] align_base(input logic [63:0] addr, input int offs);
      return addr & ~((64'd1 << offs) - 64'd1);
   endfunction

endpackage

// File: rtl/burst_line_adaptor_if.sv
// burst_line_adaptor_if: cache-side and memory-side signals of the burst line adaptor
interface burst_line_adaptor_if #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32
);
   logic [LINE_WIDTH-1:0]  line_i;
   logic [LINE_WIDTH-1:0]  line_o;
   logic [ADDR_WIDTH-1:0]  address_i;
   logic                   read_i;
   logic                   write_i;
   logic                   resp_o;
   logic                   err_o;
   logic [BURST_WIDTH-1:0] burst_i;
   logic [BURST_WIDTH-1:0] burst_o;
   logic [ADDR_WIDTH-1:0]  address_o;
   logic                   read_o;
   logic                   write_o;
   logic                   resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/burst_shift_buf.sv
// burst_shift_buf: line buffer with whole-line load, indexed beat write and indexed beat read
module burst_shift_buf #(
   parameter int  LINE_WIDTH  = 256,
   parameter int  BURST_WIDTH = 64,
   localparam int BURSTS      = LINE_WIDTH / BURST_WIDTH,
   localparam int CNT_W       = (BURSTS > 1) ? $clog2(BURSTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_load,
   input  logic [LINE_WIDTH-1:0]  i_line,
   input  logic                   i_beat_we,
   input  logic [CNT_W-1:0]       i_idx,
   input  logic [BURST_WIDTH-1:0] i_beat,
   output logic [BURST_WIDTH-1:0] o_beat,
   output logic [LINE_WIDTH-1:0]  o_line
);
   logic [LINE_WIDTH-1:0] r_buf;

   // whole-line load for writes, single-beat insert for reads; the FSM never asserts both
   always_ff @(posedge clk)
      if (rst) r_buf <= '0;
      else if (i_load) r_buf <= i_line;
      else if (i_beat_we) r_buf[i_idx*BURST_WIDTH +: BURST_WIDTH] <= i_beat;

   assign o_beat = r_buf[i_idx*BURST_WIDTH +: BURST_WIDTH];
   assign o_line = r_buf;
endmodule

// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor: serialises cache lines into memory bursts and reassembles read bursts into lines
module burst_line_adaptor import burst_adaptor_pkg::*; #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int ADDR_INCR   = 0
) (
   input logic                 clk,
   input logic                 rst,
   burst_line_adaptor_if.slave bus
);
   localparam int BURSTS = LINE_WIDTH / BURST_WIDTH;
   localparam int OFFS   = $clog2(LINE_WIDTH / 8);
   localparam int CNT_W  = (BURSTS > 1) ? $clog2(BURSTS) : 1;
   localparam int STEP   = BURST_WIDTH / 8;

   state_t                 r_state, w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [ADDR_WIDTH-1:0]  r_base;
   logic [LINE_WIDTH-1:0]  r_line, w_buf;
   logic [BURST_WIDTH-1:0] w_beat;
   logic                   r_err, r_is_rd;
   logic                   w_busy, w_last, w_acc;

   assign w_busy = (r_state == READ) || (r_state == WRITE);
   assign w_last = r_cnt == CNT_W'(BURSTS - 1);
   assign w_acc  = (r_state == IDLE) && (bus.read_i ^ bus.write_i);

   burst_shift_buf #(
      .LINE_WIDTH (LINE_WIDTH),
      .BURST_WIDTH(BURST_WIDTH)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_acc && bus.write_i),
      .i_line   (bus.line_i),
      .i_beat_we(r_state == READ && bus.resp_i),
      .i_idx    (r_cnt),
      .i_beat   (bus.burst_i),
      .o_beat   (w_beat),
      .o_line   (w_buf)
   );

   // next state plus all outputs; the completed read line is shown live during DONE, held afterwards
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        w_next = !w_acc ? IDLE : bus.read_i ? READ : WRITE;
         READ, WRITE: w_next = (bus.resp_i && w_last) ? DONE : r_state;
         DONE:        w_next = IDLE;
      endcase
      bus.read_o    = r_state == READ;
      bus.write_o   = r_state == WRITE;
      bus.resp_o    = r_state == DONE;
      bus.err_o     = r_err;
      bus.burst_o   = (r_state == WRITE) ? w_beat : '0;
      bus.address_o = !w_busy ? '0 : (ADDR_INCR != 0) ? r_base + ADDR_WIDTH'(r_cnt) * ADDR_WIDTH'(STEP) : r_base;
      bus.line_o    = (r_state == DONE && r_is_rd) ? w_buf : r_line;
   end

   // state, beat counter, captured base, sticky conflict flag and the held read line
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_base  <= '0;
         r_err   <= 1'b0;
         r_is_rd <= 1'b0;
         r_line  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && bus.read_i && bus.write_i) r_err <= 1'b1;
         if (w_acc) begin
            r_base  <= ADDR_WIDTH'(align_base(64'(bus.address_i), OFFS));
            r_cnt   <= '0;
            r_is_rd <= bus.read_i;
         end else if (w_busy && bus.resp_i && !w_last) r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == DONE && r_is_rd) r_line <= w_buf;
      end
   end
endmodule

// File: tb/tb_burst_line_adaptor.sv
// tb_burst_line_adaptor: directed bench with a transaction-level reference model for the default configuration
module tb_burst_line_adaptor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;

   always #5 clk = ~clk;

   burst_line_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64),  .ADDR_WIDTH(32)) b0();
   burst_line_adaptor_if #(.LINE_WIDTH(512), .BURST_WIDTH(128), .ADDR_WIDTH(32)) b1();
   burst_line_adaptor_if #(.LINE_WIDTH(64),  .BURST_WIDTH(64),  .ADDR_WIDTH(32)) b2();

   burst_line_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32), .ADDR_INCR(0)) u0 (
      .clk(clk), .rst(rst), .bus(b0.slave));
   burst_line_adaptor #(.LINE_WIDTH(512), .BURST_WIDTH(128), .ADDR_WIDTH(32), .ADDR_INCR(1)) u1 (
      .clk(clk), .rst(rst), .bus(b1.slave));
   burst_line_adaptor #(.LINE_WIDTH(64), .BURST_WIDTH(64), .ADDR_WIDTH(32), .ADDR_INCR(0)) u2 (
      .clk(clk), .rst(rst), .bus(b2.slave));

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model of u0: phase 0 idle, 1 reading, 2 writing, 3 completion cycle
   int           m_ph = 0;
   int           m_k = 0;
   logic [63:0]  m_beats[4];
   logic [255:0] m_wl;
   logic [255:0] m_line;
   logic [31:0]  m_base;
   logic         m_err;

   always @(posedge clk) begin
      if (rst) begin
         m_ph = 0; m_k = 0; m_line = '0; m_err = 1'b0; m_base = '0;
      end else if (m_ph == 0) begin
         if (b0.read_i && b0.write_i) m_err = 1'b1;
         else if (b0.read_i || b0.write_i) begin
            m_ph = b0.read_i ? 1 : 2;
            m_k = 0;
            m_base = b0.address_i - b0.address_i % 32;
            m_wl = b0.line_i;
         end
      end else if (m_ph == 3) m_ph = 0;
      else if (b0.resp_i) begin
         if (m_ph == 1) m_beats[m_k] = b0.burst_i;
         if (m_k == 3) begin
            if (m_ph == 1) m_line = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
            m_ph = 3;
         end else m_k++;
      end
   end

   // every-cycle comparison of u0 against the model, away from the active edge
   always @(negedge clk) if (started) begin
      chk("read_o",    512'(b0.read_o),    512'(m_ph == 1));
      chk("write_o",   512'(b0.write_o),   512'(m_ph == 2));
      chk("resp_o",    512'(b0.resp_o),    512'(m_ph == 3));
      chk("err_o",     512'(b0.err_o),     512'(m_err));
      chk("address_o", 512'(b0.address_o), 512'((m_ph == 1 || m_ph == 2) ? m_base : 32'd0));
      chk("burst_o",   512'(b0.burst_o),   512'((m_ph == 2) ? m_wl[m_k*64 +: 64] : 64'd0));
      chk("line_o",    512'(b0.line_o),    512'(m_line));
   end

   logic [63:0] got[4];
   logic [31:0] adr[4];

   task automatic xfer0(input logic rd, input logic [31:0] a, input logic [255:0] l, input int per,
                        input logic [63:0] bv, output int lat, output int pulses);
      int k, g;
      k = 0; g = 0; lat = 0; pulses = 0;
      b0.read_i = rd; b0.write_i = !rd; b0.address_i = a; b0.line_i = l;
      for (int c = 1; c <= 300 && (lat == 0 || c <= lat + 3); c++) begin
         tick();
         if (c == 1) begin
            b0.read_i = 1'b0; b0.write_i = 1'b0; b0.address_i = 32'hFFFF_FFFF;
            b0.line_i = {4{64'hDEAD_BEEF_0BAD_F00D}};
         end
         if (b0.resp_o) begin
            pulses++;
            if (lat == 0) lat = c;
         end
         b0.resp_i = 1'b0;
         if (rd ? b0.read_o : b0.write_o) begin
            if (g % per == 0) begin
               b0.resp_i = 1'b1;
               b0.burst_i = bv + 64'(k);
               if (k < 4) begin got[k] = b0.burst_o; adr[k] = b0.address_o; end
               k++;
            end
            g++;
         end
      end
      b0.resp_i = 1'b0;
   endtask

   initial begin
      int lat, np, k, nw;
      logic [31:0]  a1[4];
      logic [63:0]  wb;
      logic [31:0]  wa;
      b0.read_i = 0; b0.write_i = 0; b0.address_i = 0; b0.line_i = 0; b0.burst_i = 0; b0.resp_i = 0;
      b1.read_i = 0; b1.write_i = 0; b1.address_i = 0; b1.line_i = 0; b1.burst_i = 0; b1.resp_i = 0;
      b2.read_i = 0; b2.write_i = 0; b2.address_i = 0; b2.line_i = 0; b2.burst_i = 0; b2.resp_i = 0;
      tick();
      started = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_read_o",  512'(b0.read_o),  512'(0));
      chk("rst_write_o", 512'(b0.write_o), 512'(0));
      chk("rst_resp_o",  512'(b0.resp_o),  512'(0));
      chk("rst_err_o",   512'(b0.err_o),   512'(0));
      chk("rst_line_o",  512'(b0.line_o),  512'(0));
      chk("rst_addr_o",  512'(b0.address_o), 512'(0));

      xfer0(1'b1, 32'h1234_5678, '0, 1, 64'hA0, lat, np);
      chk("rd_latency", 512'(lat), 512'(5));
      chk("rd_pulses",  512'(np),  512'(1));
      chk("rd_addr_b0", 512'(adr[0]), 512'(32'h1234_5660));
      chk("rd_addr_b3", 512'(adr[3]), 512'(32'h1234_5660));
      chk("rd_line",    512'(b0.line_o), 512'({64'hA3, 64'hA2, 64'hA1, 64'hA0}));

      xfer0(1'b0, 32'h0000_1010, {64'h4, 64'h3, 64'h2, 64'h1}, 3, 64'h0, lat, np);
      chk("wr_beat0",   512'(got[0]), 512'(64'h1));
      chk("wr_beat1",   512'(got[1]), 512'(64'h2));
      chk("wr_beat2",   512'(got[2]), 512'(64'h3));
      chk("wr_beat3",   512'(got[3]), 512'(64'h4));
      chk("wr_pulses",  512'(np),  512'(1));
      chk("wr_latency", 512'(lat), 512'(11));
      chk("wr_addr",    512'(adr[2]), 512'(32'h0000_1000));
      chk("wr_line_kept", 512'(b0.line_o), 512'({64'hA3, 64'hA2, 64'hA1, 64'hA0}));

      b0.read_i = 1'b1; b0.write_i = 1'b1;
      tick();
      b0.read_i = 1'b0; b0.write_i = 1'b0;
      chk("err_set",     512'(b0.err_o),   512'(1));
      chk("err_no_rd",   512'(b0.read_o),  512'(0));
      chk("err_no_wr",   512'(b0.write_o), 512'(0));
      tick(); tick(); tick();
      chk("err_sticky",  512'(b0.err_o),   512'(1));
      xfer0(1'b1, 32'h0000_0047, '0, 1, 64'hB0, lat, np);
      chk("err_rd_lat",  512'(lat), 512'(5));
      chk("err_rd_line", 512'(b0.line_o), 512'({64'hB3, 64'hB2, 64'hB1, 64'hB0}));
      chk("err_kept",    512'(b0.err_o), 512'(1));

      b0.read_i = 1'b1; b0.address_i = 32'h0000_0200;
      tick();
      b0.read_i = 1'b0;
      b0.resp_i = 1'b1; b0.burst_i = 64'hC0;
      tick();
      b0.burst_i = 64'hC1;
      tick();
      b0.resp_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_read_o", 512'(b0.read_o), 512'(0));
      chk("abort_resp_o", 512'(b0.resp_o), 512'(0));
      chk("abort_line_o", 512'(b0.line_o), 512'(0));
      chk("abort_err_o",  512'(b0.err_o),  512'(0));
      xfer0(1'b1, 32'h0000_0300, '0, 1, 64'hD0, lat, np);
      chk("abort_rd_lat",  512'(lat), 512'(5));
      chk("abort_rd_line", 512'(b0.line_o), 512'({64'hD3, 64'hD2, 64'hD1, 64'hD0}));

      b1.read_i = 1'b1; b1.address_i = 32'h0000_0100;
      k = 0; lat = 0;
      for (int c = 1; c <= 50 && (lat == 0 || c <= lat + 2); c++) begin
         tick();
         if (c == 1) begin b1.read_i = 1'b0; b1.address_i = 32'h0; end
         if (b1.resp_o && lat == 0) lat = c;
         b1.resp_i = 1'b0;
         if (b1.read_o) begin
            b1.resp_i = 1'b1;
            b1.burst_i = 128'h10 + 128'(k);
            if (k < 4) a1[k] = b1.address_o;
            k++;
         end
      end
      b1.resp_i = 1'b0;
      chk("incr_addr0", 512'(a1[0]), 512'(32'h100));
      chk("incr_addr1", 512'(a1[1]), 512'(32'h110));
      chk("incr_addr2", 512'(a1[2]), 512'(32'h120));
      chk("incr_addr3", 512'(a1[3]), 512'(32'h130));
      chk("incr_lat",   512'(lat), 512'(5));
      chk("incr_line",  b1.line_o, {128'h13, 128'h12, 128'h11, 128'h10});

      b2.write_i = 1'b1; b2.address_i = 32'h0000_0047; b2.line_i = 64'hCAFE_F00D_1234_5678;
      nw = 0; lat = 0; wb = '0; wa = '0;
      for (int c = 1; c <= 50 && (lat == 0 || c <= lat + 2); c++) begin
         tick();
         if (c == 1) begin b2.write_i = 1'b0; b2.line_i = 64'h0; end
         if (b2.resp_o && lat == 0) lat = c;
         b2.resp_i = 1'b0;
         if (b2.write_o) begin
            nw++;
            b2.resp_i = 1'b1;
            wb = b2.burst_o;
            wa = b2.address_o;
         end
      end
      b2.resp_i = 1'b0;
      chk("single_lat",   512'(lat), 512'(2));
      chk("single_beats", 512'(nw),  512'(1));
      chk("single_data",  512'(wb),  512'(64'hCAFE_F00D_1234_5678));
      chk("single_addr",  512'(wa),  512'(32'h40));

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
